// File: rtl/wsg_sched_pkg.sv
// Shared types and constants for the WSG write scheduler: FSM states,
// WSG register offsets and bus widths.
package wsg_sched_pkg;

  localparam int unsigned ADDR_W     = 6;
  localparam int unsigned DATA_W     = 8;
  localparam int unsigned WSG_NUM_CH = 8;
  localparam int unsigned REG_STRIDE = 8;

  localparam int unsigned REG_CT    = 2;
  localparam int unsigned REG_VOL   = 3;
  localparam int unsigned REG_FL    = 4;
  localparam int unsigned REG_FM    = 5;
  localparam int unsigned REG_FH_FV = 6;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WRITE,
    ST_SWEEP
  } state_e;

  // Register-file address of register regoff within channel ch.
  function automatic logic [ADDR_W-1:0] wsg_addr(input int unsigned ch,
                                                 input int unsigned regoff);
    return ADDR_W'(ch * REG_STRIDE + regoff);
  endfunction

endpackage

// File: rtl/wsg_write_scheduler_rr_arb2.sv
// Two-requester round-robin arbiter; index 0 is requester A, index 1 is B.
// The last-granted pointer only moves when upd_i is high.
module rr_arb2 (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] req_i,
  input  logic       upd_i,
  output logic [1:0] gnt_o
);

  logic last_q;  // 1: B was granted last, so A wins the next tie

  always_comb begin
    gnt_o = 2'b00;
    case (req_i)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      2'b11:   gnt_o = last_q ? 2'b01 : 2'b10;
      default: gnt_o = 2'b00;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      last_q <= 1'b1;
    end else if (upd_i) begin
      last_q <= gnt_o[1];
    end
  end

endmodule

// File: rtl/wsg_write_scheduler.sv
// Single write port into the WSG register file: round-robin CPU writes
// from two requesters plus a mute sweep that zeroes every channel volume.
module wsg_write_scheduler
  import wsg_sched_pkg::*;
#(
  parameter int unsigned NUM_CH  = WSG_NUM_CH,
  parameter int unsigned VOL_REG = REG_VOL
) (
  input  logic              CLK24M,
  input  logic              RESET,
  input  logic              A_REQ,
  input  logic [ADDR_W-1:0] A_ADDR,
  input  logic [DATA_W-1:0] A_DATA,
  output logic              A_ACK,
  input  logic              B_REQ,
  input  logic [ADDR_W-1:0] B_ADDR,
  input  logic [DATA_W-1:0] B_DATA,
  output logic              B_ACK,
  input  logic              MUTE,
  output logic              MUTE_BUSY,
  output logic [ADDR_W-1:0] WSG_ADDR,
  output logic [DATA_W-1:0] WSG_DATA,
  output logic              WSG_WE
);

  localparam int unsigned K_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  state_e            state_q;
  logic              mute_q;
  logic              pending_q;
  logic [K_W-1:0]    k_q;
  logic [K_W-1:0]    k_d;
  logic              we_q;
  logic              a_ack_q;
  logic              b_ack_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;

  logic       mute_edge;
  logic       cpu_grant;
  logic [1:0] gnt;

  assign mute_edge = MUTE & ~mute_q;
  assign k_d       = k_q + 1'b1;

  // A mute edge seen in IDLE holds off CPU grants so the sweep goes first.
  assign cpu_grant = (state_q == ST_IDLE) & ~pending_q & ~mute_edge & (|gnt);

  rr_arb2 u_arb (
    .clk_i (CLK24M),
    .rst_i (RESET),
    .req_i ({B_REQ, A_REQ}),
    .upd_i (cpu_grant),
    .gnt_o (gnt)
  );

  always_ff @(posedge CLK24M or posedge RESET) begin
    if (RESET) begin
      state_q   <= ST_IDLE;
      mute_q    <= 1'b0;
      pending_q <= 1'b0;
      k_q       <= '0;
      we_q      <= 1'b0;
      a_ack_q   <= 1'b0;
      b_ack_q   <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
    end else begin
      mute_q  <= MUTE;
      we_q    <= 1'b0;
      a_ack_q <= 1'b0;
      b_ack_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (pending_q) begin
            state_q   <= ST_SWEEP;
            pending_q <= 1'b0;
            k_q       <= '0;
            we_q      <= 1'b1;
            addr_q    <= wsg_addr(0, VOL_REG);
            data_q    <= '0;
          end else if (mute_edge) begin
            pending_q <= 1'b1;
          end else if (cpu_grant) begin
            state_q <= ST_WRITE;
            we_q    <= 1'b1;
            a_ack_q <= gnt[0];
            b_ack_q <= gnt[1];
            addr_q  <= gnt[0] ? A_ADDR : B_ADDR;
            data_q  <= gnt[0] ? A_DATA : B_DATA;
          end
        end
        ST_WRITE: begin
          if (mute_edge) begin
            pending_q <= 1'b1;
          end
          state_q <= ST_IDLE;
        end
        ST_SWEEP: begin
          // Edges arriving mid-sweep are deliberately dropped.
          if (k_q == K_W'(NUM_CH - 1)) begin
            state_q <= ST_IDLE;
          end else begin
            k_q    <= k_d;
            we_q   <= 1'b1;
            addr_q <= wsg_addr(32'(k_d), VOL_REG);
            data_q <= '0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign WSG_WE    = we_q;
  assign WSG_ADDR  = addr_q;
  assign WSG_DATA  = data_q;
  assign A_ACK     = a_ack_q;
  assign B_ACK     = b_ack_q;
  assign MUTE_BUSY = pending_q | (state_q == ST_SWEEP);

endmodule

// File: tb/tb_wsg_write_scheduler.sv
// Scoreboard bench for wsg_write_scheduler: expected WSG writes are queued
// as stimulus is issued and matched against each WE strobe.
module tb_wsg_write_scheduler;

  logic       clk;
  logic       RESET;
  logic       A_REQ, B_REQ, MUTE;
  logic [5:0] A_ADDR, B_ADDR;
  logic [7:0] A_DATA, B_DATA;
  logic       A_ACK, B_ACK, MUTE_BUSY, WSG_WE;
  logic [5:0] WSG_ADDR;
  logic [7:0] WSG_DATA;

  typedef struct {
    logic [5:0] addr;
    logic [7:0] data;
    logic       a;
    logic       b;
  } exp_t;

  typedef struct {
    logic [5:0] addr;
    logic [7:0] data;
  } tx_t;

  exp_t sb[$];
  tx_t  a_txq[$];
  tx_t  b_txq[$];

  int n_checks = 0;
  int n_errs   = 0;
  int cyc      = 0;
  int n_we     = 0;
  int prev_we_cyc = -1;
  bit gap_chk  = 1'b0;
  bit a_acked  = 1'b0;
  bit b_acked  = 1'b0;

  wsg_write_scheduler #(.NUM_CH(8), .VOL_REG(3)) dut (
    .CLK24M    (clk),
    .RESET     (RESET),
    .A_REQ     (A_REQ),
    .A_ADDR    (A_ADDR),
    .A_DATA    (A_DATA),
    .A_ACK     (A_ACK),
    .B_REQ     (B_REQ),
    .B_ADDR    (B_ADDR),
    .B_DATA    (B_DATA),
    .B_ACK     (B_ACK),
    .MUTE      (MUTE),
    .MUTE_BUSY (MUTE_BUSY),
    .WSG_ADDR  (WSG_ADDR),
    .WSG_DATA  (WSG_DATA),
    .WSG_WE    (WSG_WE)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic push_exp(input logic [5:0] addr, input logic [7:0] data,
                          input logic a, input logic b);
    exp_t e;
    e.addr = addr; e.data = data; e.a = a; e.b = b;
    sb.push_back(e);
  endtask

  task automatic push_tx(input bit to_b, input logic [5:0] addr, input logic [7:0] data);
    tx_t t;
    t.addr = addr; t.data = data;
    if (to_b) b_txq.push_back(t);
    else      a_txq.push_back(t);
    push_exp(addr, data, !to_b, to_b);
  endtask

  task automatic push_sweep();
    for (int unsigned k = 0; k < 8; k++) push_exp(6'(k * 8 + 3), 8'h00, 1'b0, 1'b0);
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (sb.size() != 0 && n < budget) begin
      step();
      n++;
    end
    repeat (2) step();
    check_eq("drain", sb.size(), 0);
  endtask

  // Requester agents: hold REQ/ADDR/DATA until ACK, change on the cycle after.
  always @(negedge clk) begin
    if (A_ACK) a_acked = 1'b1;
    if (B_ACK) b_acked = 1'b1;
  end

  always @(posedge clk) begin
    tx_t t;
    #1;
    if (RESET) begin
      A_REQ = 1'b0; a_acked = 1'b0;
    end else if (!A_REQ || a_acked) begin
      a_acked = 1'b0;
      if (a_txq.size() != 0) begin
        t = a_txq.pop_front();
        A_ADDR = t.addr; A_DATA = t.data; A_REQ = 1'b1;
      end else begin
        A_REQ = 1'b0;
      end
    end
  end

  always @(posedge clk) begin
    tx_t t;
    #1;
    if (RESET) begin
      B_REQ = 1'b0; b_acked = 1'b0;
    end else if (!B_REQ || b_acked) begin
      b_acked = 1'b0;
      if (b_txq.size() != 0) begin
        t = b_txq.pop_front();
        B_ADDR = t.addr; B_DATA = t.data; B_REQ = 1'b1;
      end else begin
        B_REQ = 1'b0;
      end
    end
  end

  // Write monitor / scoreboard consumer.
  always @(negedge clk) begin
    exp_t e;
    if (!RESET) begin
      if (WSG_WE) begin
        n_we++;
        if (gap_chk && prev_we_cyc >= 0) check_eq("we_gap", cyc - prev_we_cyc, 2);
        prev_we_cyc = cyc;
        if (sb.size() == 0) begin
          check_eq("unexp_we", WSG_WE, 1'b0);
        end else begin
          e = sb.pop_front();
          check_eq("wr_addr", WSG_ADDR, e.addr);
          check_eq("wr_data", WSG_DATA, e.data);
          check_eq("wr_a_ack", A_ACK, e.a);
          check_eq("wr_b_ack", B_ACK, e.b);
        end
      end else begin
        check_eq("ack_no_we", {A_ACK, B_ACK}, 2'b00);
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int n0;
    RESET = 1'b1; MUTE = 1'b0;
    A_REQ = 1'b0; B_REQ = 1'b0;
    A_ADDR = '0; A_DATA = '0; B_ADDR = '0; B_DATA = '0;
    repeat (3) step();
    @(negedge clk);
    check_eq("rst_we",   WSG_WE, 1'b0);
    check_eq("rst_addr", WSG_ADDR, 6'h00);
    check_eq("rst_data", WSG_DATA, 8'h00);
    check_eq("rst_acks", {A_ACK, B_ACK}, 2'b00);
    check_eq("rst_busy", MUTE_BUSY, 1'b0);
    step();
    RESET = 1'b0;
    repeat (2) step();

    // Single A write: WE and ACK exactly one cycle after REQ.
    push_tx(1'b0, 6'h0B, 8'h0F);
    step();
    @(negedge clk);
    check_eq("t1_req_seen", A_REQ, 1'b1);
    check_eq("t1_we_early", WSG_WE, 1'b0);
    step();
    @(negedge clk);
    check_eq("t1_we",   WSG_WE, 1'b1);
    check_eq("t1_addr", WSG_ADDR, 6'h0B);
    check_eq("t1_data", WSG_DATA, 8'h0F);
    check_eq("t1_acks", {A_ACK, B_ACK}, 2'b10);
    wait_drain(10);

    // Single B write leaves last=B so the following tie starts with A.
    push_tx(1'b1, 6'h05, 8'hB5);
    wait_drain(10);

    // Continuous contention: strict A,B alternation, one write per 2 cycles.
    prev_we_cyc = -1;
    gap_chk = 1'b1;
    push_tx(1'b0, 6'h10, 8'hA1); push_tx(1'b1, 6'h20, 8'hB1);
    push_tx(1'b0, 6'h12, 8'hA2); push_tx(1'b1, 6'h22, 8'hB2);
    push_tx(1'b0, 6'h14, 8'hA3); push_tx(1'b1, 6'h24, 8'hB3);
    // The queue pushes above interleave A/B in scoreboard order already.
    wait_drain(30);
    gap_chk = 1'b0;

    // Mute in IDLE: busy N+1..N+9, WE N+2..N+9.
    step();
    MUTE = 1'b1;
    push_sweep();
    for (int i = 0; i <= 10; i++) begin
      @(negedge clk);
      check_eq($sformatf("idle_busy_%0d", i), MUTE_BUSY, (i >= 1 && i <= 9));
      check_eq($sformatf("idle_we_%0d", i), WSG_WE, (i >= 2 && i <= 9));
    end
    step();
    MUTE = 1'b0;
    wait_drain(5);

    // Mute edge together with B request: sweep first, then B.
    b_txq.push_back('{6'h07, 8'h77});
    step();
    MUTE = 1'b1;
    push_sweep();
    push_exp(6'h07, 8'h77, 1'b0, 1'b1);
    step();
    @(negedge clk);
    check_eq("mb_hold_we",  WSG_WE, 1'b0);
    check_eq("mb_hold_ack", B_ACK, 1'b0);
    check_eq("mb_busy",     MUTE_BUSY, 1'b1);
    wait_drain(20);
    MUTE = 1'b0;
    push_tx(1'b0, 6'h30, 8'hC1); push_tx(1'b1, 6'h31, 8'hC2);
    wait_drain(10);

    // Second mute edge during a sweep is ignored.
    step();
    MUTE = 1'b1;
    push_sweep();
    n0 = n_we;
    repeat (4) step();
    MUTE = 1'b0;
    step();
    MUTE = 1'b1;
    repeat (14) step();
    check_eq("resweep_cnt", n_we - n0, 8);
    check_eq("resweep_busy", MUTE_BUSY, 1'b0);
    MUTE = 1'b0;
    wait_drain(5);

    // Mute edge during WRITE: sweep starts right after the next IDLE cycle.
    push_tx(1'b0, 6'h2A, 8'h5A);
    push_sweep();
    step();
    step();
    MUTE = 1'b1;
    @(negedge clk);
    check_eq("mw_write", {WSG_WE, A_ACK}, 2'b11);
    step();
    @(negedge clk);
    check_eq("mw_gap_we",  WSG_WE, 1'b0);
    check_eq("mw_gap_busy", MUTE_BUSY, 1'b1);
    step();
    @(negedge clk);
    check_eq("mw_first", {WSG_WE, WSG_ADDR}, {1'b1, 6'd3});
    wait_drain(15);
    MUTE = 1'b0;

    // Reset asserted at sweep write k=3 aborts the sweep.
    step();
    MUTE = 1'b1;
    push_sweep();
    repeat (5) step();
    check_eq("rs_k3", {WSG_WE, WSG_ADDR}, {1'b1, 6'd27});
    RESET = 1'b1;
    #1;
    check_eq("rs_we",   WSG_WE, 1'b0);
    check_eq("rs_addr", WSG_ADDR, 6'h00);
    check_eq("rs_data", WSG_DATA, 8'h00);
    check_eq("rs_acks", {A_ACK, B_ACK}, 2'b00);
    check_eq("rs_busy", MUTE_BUSY, 1'b0);
    sb.delete();
    MUTE = 1'b0;
    repeat (2) step();
    RESET = 1'b0;
    n0 = n_we;
    repeat (12) step();
    check_eq("rs_quiet", n_we - n0, 0);
    check_eq("rs_quiet_busy", MUTE_BUSY, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
    $finish;
  end

endmodule
